// File: rtl/sampframe_tx.sv
`default_nettype none
// ============================================================================
// Module   : sampframe_tx
// Purpose  : Pulls 32-bit samples from the sample queue and frames them into
//            checksummed byte packets on a valid/ready byte stream.
// Revision : 1.0
// ============================================================================
module sampframe_tx #(
    parameter int         MAX_SAMPLES = 16,
    parameter logic [7:0] SYNC_BYTE   = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [31:0] samp_stream_data,
    input  logic [7:0]  samp_stream_count,
    input  logic        samp_stream_avail,
    output logic        samp_stream_pull,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic [7:0]  pkt_seq
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SYNC = 3'd1;
    localparam logic [2:0] S_SEQ  = 3'd2;
    localparam logic [2:0] S_CNT  = 3'd3;
    localparam logic [2:0] S_LOAD = 3'd4;
    localparam logic [2:0] S_DATA = 3'd5;
    localparam logic [2:0] S_CSUM = 3'd6;

    localparam logic [7:0] C_MAX = 8'(MAX_SAMPLES);

    logic [2:0]  state_q,    state_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_data_q,  tx_data_d;
    logic        pull_q,     pull_d;
    logic [7:0]  seq_q,      seq_d;
    logic [7:0]  n_q,        n_d;
    logic [7:0]  rem_q,      rem_d;
    logic [7:0]  csum_q,     csum_d;
    logic [31:0] shift_q,    shift_d;
    logic [1:0]  idx_q,      idx_d;

    logic       w_accept;
    logic [7:0] w_n;

    assign w_accept = tx_valid_q && tx_ready;
    assign w_n      = (samp_stream_count > C_MAX) ? C_MAX : samp_stream_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            pull_q     <= 1'b0;
            seq_q      <= 8'h00;
            n_q        <= 8'h00;
            rem_q      <= 8'h00;
            csum_q     <= 8'h00;
            shift_q    <= 32'h0;
            idx_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            pull_q     <= pull_d;
            seq_q      <= seq_d;
            n_q        <= n_d;
            rem_q      <= rem_d;
            csum_q     <= csum_d;
            shift_q    <= shift_d;
            idx_q      <= idx_d;
        end
    end

    // Each byte is folded into the checksum at the moment it is accepted.
    always_comb begin
        state_d    = state_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        pull_d     = 1'b0;
        seq_d      = seq_q;
        n_d        = n_q;
        rem_d      = rem_q;
        csum_d     = csum_q;
        shift_d    = shift_q;
        idx_d      = idx_q;
        case (state_q)
            S_IDLE: begin
                if (enable && samp_stream_avail && (samp_stream_count != 8'h00)) begin
                    state_d    = S_SYNC;
                    n_d        = w_n;
                    rem_d      = w_n;
                    csum_d     = 8'h00;
                    tx_valid_d = 1'b1;
                    tx_data_d  = SYNC_BYTE;
                end
            end
            S_SYNC: begin
                if (w_accept) begin
                    state_d   = S_SEQ;
                    tx_data_d = seq_q;
                end
            end
            S_SEQ: begin
                if (w_accept) begin
                    state_d   = S_CNT;
                    tx_data_d = n_q;
                    csum_d    = csum_q ^ tx_data_q;
                end
            end
            S_CNT: begin
                if (w_accept) begin
                    state_d    = S_LOAD;
                    tx_valid_d = 1'b0;
                    pull_d     = 1'b1;
                    csum_d     = csum_q ^ tx_data_q;
                end
            end
            S_LOAD: begin
                // Byte 0 goes straight to the output; the register keeps the upper three.
                state_d    = S_DATA;
                shift_d    = {8'h00, samp_stream_data[31:8]};
                tx_data_d  = samp_stream_data[7:0];
                tx_valid_d = 1'b1;
                rem_d      = rem_q - 8'd1;
                idx_d      = 2'd0;
            end
            S_DATA: begin
                if (w_accept) begin
                    csum_d    = csum_q ^ tx_data_q;
                    shift_d   = shift_q >> 8;
                    tx_data_d = shift_q[7:0];
                    idx_d     = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        if (rem_q != 8'h00) begin
                            state_d    = S_LOAD;
                            tx_valid_d = 1'b0;
                            pull_d     = 1'b1;
                        end else begin
                            state_d   = S_CSUM;
                            tx_data_d = csum_q ^ tx_data_q;
                        end
                    end
                end
            end
            S_CSUM: begin
                if (w_accept) begin
                    state_d    = S_IDLE;
                    tx_valid_d = 1'b0;
                    seq_d      = seq_q + 8'd1;
                end
            end
            default: begin
                state_d    = S_IDLE;
                tx_valid_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        busy             = (state_q != S_IDLE);
        tx_valid         = tx_valid_q;
        tx_data          = tx_data_q;
        samp_stream_pull = pull_q;
        pkt_seq          = seq_q;
    end

endmodule
`default_nettype wire

// File: doc/sampframe_tx.md
# sampframe_tx

Consumer end of the sample stream produced by the sample queue. Pulls 32-bit samples via the `samp_stream_*` handshake and serialises them into checksummed byte packets on a valid/ready byte stream toward the host transport. Sits between the sample queue and the host USB/UART byte mux.

## Interface
- `MAX_SAMPLES`, default 16: maximum samples per packet (1..255).
- `SYNC_BYTE`, default 8'hA5: first byte of every packet.

- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `enable` in 1: permits starting new packets.
- `samp_stream_data` in 32: head sample of the queue.
- `samp_stream_count` in 8: samples available (registered by producer).
- `samp_stream_avail` in 1: producer has a packet's worth ready.
- `samp_stream_pull` out 1: one-cycle pulse consumes head sample.
- `tx_data` out 8: packet byte.
- `tx_valid` out 1: `tx_data` valid.
- `tx_ready` in 1: sink accepts byte when `tx_valid && tx_ready`.
- `busy` out 1: high in any state other than IDLE.
- `pkt_seq` out 8: sequence number of the next packet to start.

## Operation
- Packet: SYNC_BYTE, seq, N, then N samples little-endian (4N bytes), then checksum. Length 4N+4 bytes.
- Checksum: XOR of seq, N and all data bytes. SYNC is excluded.
- States: IDLE, SYNC, SEQ, CNT, LOAD, DATA (byte index 0..3), CSUM.
- IDLE -> SYNC when `enable && samp_stream_avail && samp_stream_count != 0`.
  - Latch N = min(`samp_stream_count`, MAX_SAMPLES) and the remaining count = N.
  - Clear the checksum.
- SYNC -> SEQ -> CNT, each on byte acceptance.
- CNT -> LOAD on acceptance.
- LOAD (exactly 1 cycle):
  - Assert `samp_stream_pull`.
  - Latch `samp_stream_data` into the shift register.
  - Decrement remaining. `tx_valid` is 0.
  - Go to DATA, index 0.
- DATA: emit shift[7:0], shift right 8 on acceptance.
  - After index 3 is accepted: go to LOAD if remaining != 0, else CSUM.
- CSUM -> IDLE on acceptance; `pkt_seq` increments mod 256.
- `enable` only gates the IDLE exit. Deasserting it mid-packet completes the current packet.
- Pulls per packet equal N exactly. N <= count guarantees the producer holds every pulled sample.
- `samp_stream_avail && count == 0` in IDLE: stay in IDLE.

## Timing
- Reset values:
  - state IDLE
  - `tx_valid` 0, `tx_data` 0
  - `samp_stream_pull` 0
  - `busy` 0
  - `pkt_seq` 0
  - checksum 0, shift register 0
- `tx_valid`, `tx_data` and `samp_stream_pull` are registered outputs.
- `tx_data` is held stable while `tx_valid && !tx_ready`.
- Start latency: `avail` sampled high in IDLE at cycle 0 -> `tx_valid` high with SYNC at cycle 1.
- With `tx_ready` tied high:
  - Header takes 3 cycles.
  - Each sample takes 5 cycles (LOAD + 4 bytes).
  - Checksum takes 1 cycle.
  - Total busy time is 4+5N cycles, then a minimum of 1 cycle in IDLE.
- Pull spacing is >= 5 cycles, which exceeds the producer's pointer + RAM read latency (2 cycles). No `samp_stream_data` read occurs within 2 cycles of a pull.
- The IDLE re-entry gap lets the registered `count`/`avail` reflect the last pull before the next start decision. The last pull precedes IDLE by >= 5 cycles.
- Async reset mid-packet:
  - `tx_valid` and `samp_stream_pull` drop immediately.
  - The partial packet is abandoned and samples already pulled are lost.
  - `pkt_seq` returns to 0.

## Test plan
- Single sample 0x11223344, count=1, ready high -> bytes A5 00 01 44 33 22 11 45.
  - Exactly one pull pulse.
  - `busy` high for 9 cycles.
  - `pkt_seq`=1 afterward.
- count=200, MAX_SAMPLES=16, incrementing samples -> N byte = 0x10 and 16 pulls, each >= 5 cycles apart.
  - 68 bytes with correct XOR.
  - A second packet follows with seq 01.
- Random `tx_ready` backpressure (50% duty) over a 4-sample packet:
  - `tx_data` stable whenever valid && !ready.
  - Byte sequence identical to the ready-high run.
  - No pull during a stalled DATA byte.
- `enable` dropped during DATA of packet 0:
  - Packet 0 completes with correct checksum.
  - No new SYNC while `enable`=0 even with `avail` high.
  - Re-enable -> packet with seq 01.
- `rst` asserted at byte 5 of a packet:
  - `tx_valid`=0 and `pull`=0 in the same cycle.
  - After release, the next packet starts with A5 00.
- 256 consecutive one-sample packets -> seq field wraps FF -> 00; checksum correct on every packet.
- avail=1 with count=0 -> stays IDLE, no pull, `busy`=0.
